retrig_interval_counter: RTL and testbench
==========================================

// Module: retrig_interval_counter
// PURPOSE
//   Parametrised interval counter started by a slow tick on the fast clk domain.
//   Counts 0..term, then either stops with done held (one-shot) or reloads to 0 (auto-reload).
//   Gates timed game/display intervals; successor to the fixed 13-bit MAXCOUNT counter.
//   Adds async reset, a tick synchroniser, a run-time terminal value, busy, wrap and overrun flags.
// PARAMETERS
//   WIDTH        13  counter width in bits; term and count are WIDTH bits
//   AUTO_RELOAD  0   0 = one-shot (stop in DONE); 1 = free-running reload at terminal
// PORTS
//   clk       in   1      system clock; all state on posedge
//   resetn    in   1      asynchronous active-low reset
//   enable    in   1      synchronous run enable; low = force IDLE (highest sync priority)
//   trigger   in   1      slow tick / slow_clk level, asynchronous to clk
//   term      in   WIDTH  terminal count, sampled only on the start cycle
//   count     out  WIDTH  current count, registered
//   busy      out  1      high while in COUNT
//   done      out  1      high while in DONE (one-shot complete)
//   wrap      out  1      one-cycle pulse on each reload (AUTO_RELOAD=1 only)
//   overrun   out  1      sticky: trigger edge seen while busy
// BEHAVIOUR
//   Reset (resetn=0, async): state=IDLE, count=0, busy=0, done=0, wrap=0, overrun=0.
//     Sync flops s1..s3 = 0.
//   Sync: s1<=trigger, s2<=s1, s3<=s2.
//     rise = s2 & ~s3, active only when enable=1.
//     trigger high before edge E1 -> rise during cycle after E2 -> state change on edge E3.
//   States: IDLE, COUNT, DONE (2-bit encoding; unused code -> IDLE).
//   enable=0: next state IDLE, count<=0, wrap<=0, overrun<=0.
//     Overrides all events, including a rise or terminal in the same cycle.
//   IDLE:  on rise -> COUNT, count<=0, term_q<=term. Otherwise hold.
//   COUNT: if count==term_q:
//     AUTO_RELOAD=0 -> DONE, count holds term_q.
//     AUTO_RELOAD=1 -> stay in COUNT, count<=0, wrap<=1 for exactly one cycle.
//     Otherwise count<=count+1 (no wrap possible, since count<=term_q).
//     A rise in COUNT is not a restart; it sets overrun<=1.
//   DONE:  count holds. On rise -> COUNT, count<=0, term_q<=term (retrigger).
//   Outputs: busy = (state==COUNT), done = (state==DONE); both registered with state.
//   Interval length: COUNT occupies term_q+1 cycles per pass.
//   term_q=0: one-shot spends 1 cycle in COUNT; auto-reload pulses wrap every cycle.
//   Simultaneous rise and terminal in COUNT: terminal action taken, overrun<=1.
//     No restart in that case.
//   Changing term mid-count has no effect until the next start.
//   Reset asserted mid-count: immediate return to reset values, independent of clk.
// TESTING
//   T1 reset: resetn=0 mid-count (count=5) -> all outputs 0 at once.
//     Then resetn=1, enable=1, no trigger -> IDLE, count=0.
//   T2 one-shot: AUTO_RELOAD=0, term=4, trigger high before E1 -> busy=1 after E3.
//     count 0,1,2,3,4, then done=1 with count=4 held.
//   T3 auto-reload: AUTO_RELOAD=1, term=2 -> count 0,1,2,0,1,2...
//     wrap=1 for one cycle each time count returns to 0; done stays 0.
//   T4 overrun: term=10, second trigger edge while count=3 -> overrun=1, count continues.
//     Later enable=0 for one cycle -> IDLE, count=0, overrun=0.
//   T5 retrigger and term=0: from DONE, set term=0 and pulse trigger.
//     busy=1 for exactly 1 cycle, then done=1, count=0.
//   T6 enable priority: enable=0 in the same cycle as a rise and as count==term_q.
//     State -> IDLE, count=0, wrap=0, done=0.

Source files
------------

// File: rtl/retrig_interval_counter.sv
// Retriggerable interval counter: a synchronised slow trigger starts a 0..term count,
// ending in a held DONE (one-shot) or reloading to 0 with a wrap pulse (auto-reload).
module retrig_interval_counter #(
  parameter int unsigned WIDTH       = 13,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             trigger,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_r, state_n;
  logic [WIDTH-1:0] count_r, count_n;
  logic [WIDTH-1:0] term_r, term_n;
  logic             wrap_r, wrap_n;
  logic             overrun_r, overrun_n;
  logic             busy_r, done_r;
  logic             s1_r, s2_r, s3_r;
  logic             rise_s;

  // Three-flop synchroniser; s3 only serves edge detection on the settled s2.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= trigger;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_s = s2_r & ~s3_r & enable;

  // Next-state logic; enable=0 overrides every event in the same cycle.
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    term_n    = term_r;
    wrap_n    = 1'b0;
    overrun_n = overrun_r;
    if (!enable) begin
      state_n   = IDLE;
      count_n   = {WIDTH{1'b0}};
      overrun_n = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_n = COUNT;
            count_n = {WIDTH{1'b0}};
            term_n  = term;
          end else begin
            state_n = IDLE;
          end
        end
        COUNT: begin
          // A rise while busy never restarts the interval; it is only flagged.
          if (rise_s) begin
            overrun_n = 1'b1;
          end else begin
            overrun_n = overrun_r;
          end
          if (count_r == term_r) begin
            if (AUTO_RELOAD) begin
              count_n = {WIDTH{1'b0}};
              wrap_n  = 1'b1;
            end else begin
              state_n = DONE;
            end
          end else begin
            count_n = count_r + WIDTH'(1);
          end
        end
        DONE: begin
          if (rise_s) begin
            state_n = COUNT;
            count_n = {WIDTH{1'b0}};
            term_n  = term;
          end else begin
            state_n = DONE;
          end
        end
        default: begin
          state_n = IDLE;
          count_n = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State and output registers; busy/done are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      count_r   <= {WIDTH{1'b0}};
      term_r    <= {WIDTH{1'b0}};
      wrap_r    <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      term_r    <= term_n;
      wrap_r    <= wrap_n;
      overrun_r <= overrun_n;
      busy_r    <= (state_n == COUNT);
      done_r    <= (state_n == DONE);
    end
  end

  assign count   = count_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign wrap    = wrap_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_retrig_interval_counter.sv
// Directed bench: a one-shot and an auto-reload instance share clock, reset, enable and trigger.
module tb_retrig_interval_counter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        trigger;
  logic [12:0] term_os, term_ar;
  logic [12:0] count_os, count_ar;
  logic        busy_os, done_os, wrap_os, overrun_os;
  logic        busy_ar, done_ar, wrap_ar, overrun_ar;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  retrig_interval_counter #(.WIDTH(13), .AUTO_RELOAD(1'b0)) dut_os (
    .clk(clk), .resetn(resetn), .enable(enable), .trigger(trigger), .term(term_os),
    .count(count_os), .busy(busy_os), .done(done_os), .wrap(wrap_os), .overrun(overrun_os)
  );

  retrig_interval_counter #(.WIDTH(13), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .resetn(resetn), .enable(enable), .trigger(trigger), .term(term_ar),
    .count(count_ar), .busy(busy_ar), .done(done_ar), .wrap(wrap_ar), .overrun(overrun_ar)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Force both instances to IDLE and let the synchroniser drain with trigger low.
  task automatic quiesce();
    trigger = 1'b0;
    enable  = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({count_os, busy_os, done_os, wrap_os, overrun_os} !== 17'd0)
      $display("FAIL reset_init os: got %h expected 0", {count_os, busy_os, done_os, wrap_os, overrun_os});
    else pass_cnt++;
    resetn = 1'b1; enable = 1'b1; term_os = 13'd10; term_ar = 13'd10; trigger = 1'b1;
    tick(3);
    tick(5);
    total_cnt++;
    if (count_os !== 13'd5) $display("FAIL reset_pre_count: got %0d expected 5", count_os);
    else pass_cnt++;
    #3 resetn = 1'b0;
    #1;
    total_cnt++;
    if ({count_os, busy_os, done_os, wrap_os, overrun_os} !== 17'd0)
      $display("FAIL reset_async os: got %h expected 0", {count_os, busy_os, done_os, wrap_os, overrun_os});
    else pass_cnt++;
    total_cnt++;
    if ({count_ar, busy_ar, done_ar, wrap_ar, overrun_ar} !== 17'd0)
      $display("FAIL reset_async ar: got %h expected 0", {count_ar, busy_ar, done_ar, wrap_ar, overrun_ar});
    else pass_cnt++;
    trigger = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(4);
    total_cnt++;
    if ({count_os, busy_os, done_os} !== 15'd0)
      $display("FAIL reset_release_idle: got %h expected 0", {count_os, busy_os, done_os});
    else pass_cnt++;
  endtask

  task automatic test_one_shot();
    quiesce();
    term_os = 13'd4;
    trigger = 1'b1;
    tick(2);
    total_cnt++;
    if (busy_os !== 1'b0) $display("FAIL os_latency: busy got %b expected 0 after E2", busy_os);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({busy_os, count_os} !== {1'b1, 13'd0}) $display("FAIL os_start: busy/count got %b/%0d expected 1/0", busy_os, count_os);
    else pass_cnt++;
    term_os = 13'd1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      total_cnt++;
      if ({busy_os, done_os, count_os} !== {1'b1, 1'b0, 13'(i)})
        $display("FAIL os_count: busy/done/count got %b/%b/%0d expected 1/0/%0d", busy_os, done_os, count_os, i);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total_cnt++;
      if ({busy_os, done_os, count_os} !== {1'b0, 1'b1, 13'd4})
        $display("FAIL os_done_hold: busy/done/count got %b/%b/%0d expected 0/1/4", busy_os, done_os, count_os);
      else pass_cnt++;
    end
  endtask

  task automatic test_auto_reload();
    int exp_c;
    quiesce();
    term_ar = 13'd2;
    trigger = 1'b1;
    tick(3);
    total_cnt++;
    if ({busy_ar, wrap_ar, count_ar} !== {1'b1, 1'b0, 13'd0})
      $display("FAIL ar_start: busy/wrap/count got %b/%b/%0d expected 1/0/0", busy_ar, wrap_ar, count_ar);
    else pass_cnt++;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_c = k % 3;
      total_cnt++;
      if ({busy_ar, done_ar, wrap_ar, count_ar} !== {1'b1, 1'b0, (exp_c == 0), 13'(exp_c)})
        $display("FAIL ar_seq k=%0d: busy/done/wrap/count got %b/%b/%b/%0d expected 1/0/%b/%0d",
                 k, busy_ar, done_ar, wrap_ar, count_ar, (exp_c == 0), exp_c);
      else pass_cnt++;
    end
    quiesce();
    term_ar = 13'd0;
    trigger = 1'b1;
    tick(3);
    total_cnt++;
    if ({busy_ar, wrap_ar, count_ar} !== {1'b1, 1'b0, 13'd0})
      $display("FAIL ar_t0_start: busy/wrap/count got %b/%b/%0d expected 1/0/0", busy_ar, wrap_ar, count_ar);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      total_cnt++;
      if ({busy_ar, wrap_ar, count_ar} !== {1'b1, 1'b1, 13'd0})
        $display("FAIL ar_t0_wrap: busy/wrap/count got %b/%b/%0d expected 1/1/0", busy_ar, wrap_ar, count_ar);
      else pass_cnt++;
    end
  endtask

  task automatic test_overrun();
    quiesce();
    term_os = 13'd10;
    trigger = 1'b1;
    tick(3);
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    tick(2);
    total_cnt++;
    if ({count_os, overrun_os} !== {13'd3, 1'b0})
      $display("FAIL ovr_before: count/overrun got %0d/%b expected 3/0", count_os, overrun_os);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({busy_os, count_os, overrun_os} !== {1'b1, 13'd4, 1'b1})
      $display("FAIL ovr_set: busy/count/overrun got %b/%0d/%b expected 1/4/1", busy_os, count_os, overrun_os);
    else pass_cnt++;
    tick(2);
    total_cnt++;
    if ({count_os, overrun_os} !== {13'd6, 1'b1})
      $display("FAIL ovr_sticky: count/overrun got %0d/%b expected 6/1", count_os, overrun_os);
    else pass_cnt++;
    enable = 1'b0;
    tick(1);
    total_cnt++;
    if ({busy_os, done_os, count_os, overrun_os} !== {1'b0, 1'b0, 13'd0, 1'b0})
      $display("FAIL ovr_clear: busy/done/count/overrun got %b/%b/%0d/%b expected 0/0/0/0", busy_os, done_os, count_os, overrun_os);
    else pass_cnt++;
    enable = 1'b1;
    tick(2);
    total_cnt++;
    if ({busy_os, count_os} !== {1'b0, 13'd0})
      $display("FAIL ovr_stay_idle: busy/count got %b/%0d expected 0/0", busy_os, count_os);
    else pass_cnt++;
  endtask

  task automatic test_retrigger_term0();
    quiesce();
    term_os = 13'd1;
    trigger = 1'b1;
    tick(5);
    total_cnt++;
    if ({done_os, count_os} !== {1'b1, 13'd1})
      $display("FAIL rt_first_done: done/count got %b/%0d expected 1/1", done_os, count_os);
    else pass_cnt++;
    trigger = 1'b0;
    tick(3);
    term_os = 13'd0;
    trigger = 1'b1;
    tick(2);
    total_cnt++;
    if ({busy_os, done_os} !== 2'b01) $display("FAIL rt_wait: busy/done got %b/%b expected 0/1", busy_os, done_os);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({busy_os, done_os, count_os} !== {1'b1, 1'b0, 13'd0})
      $display("FAIL rt_restart: busy/done/count got %b/%b/%0d expected 1/0/0", busy_os, done_os, count_os);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      total_cnt++;
      if ({busy_os, done_os, count_os} !== {1'b0, 1'b1, 13'd0})
        $display("FAIL rt_t0_done: busy/done/count got %b/%b/%0d expected 0/1/0", busy_os, done_os, count_os);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_priority();
    quiesce();
    term_os = 13'd3;
    term_ar = 13'd3;
    trigger = 1'b1;
    tick(3);
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    tick(2);
    total_cnt++;
    if ({count_os, count_ar} !== {13'd3, 13'd3})
      $display("FAIL en_setup: count os/ar got %0d/%0d expected 3/3", count_os, count_ar);
    else pass_cnt++;
    enable = 1'b0;
    tick(1);
    total_cnt++;
    if ({busy_os, done_os, wrap_os, overrun_os, count_os} !== {4'b0000, 13'd0})
      $display("FAIL en_prio os: busy/done/wrap/ovr/count got %b/%b/%b/%b/%0d expected 0/0/0/0/0",
               busy_os, done_os, wrap_os, overrun_os, count_os);
    else pass_cnt++;
    total_cnt++;
    if ({busy_ar, done_ar, wrap_ar, overrun_ar, count_ar} !== {4'b0000, 13'd0})
      $display("FAIL en_prio ar: busy/done/wrap/ovr/count got %b/%b/%b/%b/%0d expected 0/0/0/0/0",
               busy_ar, done_ar, wrap_ar, overrun_ar, count_ar);
    else pass_cnt++;
    enable = 1'b1;
    tick(2);
    total_cnt++;
    if ({busy_os, busy_ar, count_os} !== {2'b00, 13'd0})
      $display("FAIL en_after: busy os/ar/count got %b/%b/%0d expected 0/0/0", busy_os, busy_ar, count_os);
    else pass_cnt++;
  endtask

  initial begin
    resetn  = 1'b0;
    enable  = 1'b0;
    trigger = 1'b0;
    term_os = 13'd0;
    term_ar = 13'd0;
    tick(3);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_overrun();
    test_retrigger_term0();
    test_enable_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
